conv_loop_scheduler: RTL and testbench

- Central sequencer for the convolution datapath inside top_system.
- Walks the full loop nest: output y, output x, output channel, kernel y, kernel x, input channel.
- Jointly handshakes the activation (a) and weight (b) input streams, and drives MAC enable/clear and zero-padding controls to the datapath.
- Pulses output_valid with the output coordinates once each accumulation completes.

---
 rtl/conv_pkg.sv | 32 +++
 rtl/conv_loop_scheduler_wrap_counter.sv | 29 ++
 rtl/conv_loop_scheduler.sv | 130 +++++++++++++
 tb/tb_conv_loop_scheduler.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and sizing helpers for the convolution loop scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package conv_pkg;

  // Scheduler phases: wait for start, consume taps, report one finished result.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    OUTPUT = 2'd2
  } sched_state_t;

  // Default layer geometry.
  localparam int DEF_FEATURE_MAP_WIDTH  = 128;
  localparam int DEF_FEATURE_MAP_HEIGHT = 128;
  localparam int DEF_INPUT_NB_CHANNELS  = 2;
  localparam int DEF_OUTPUT_NB_CHANNELS = 16;
  localparam int DEF_KERNEL_SIZE        = 3;

  // Counter width that never collapses to zero bits for a loop of one.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int KERNEL_HALF = DEF_KERNEL_SIZE / 2;
  localparam int X_W  = cnt_w(DEF_FEATURE_MAP_WIDTH);
  localparam int Y_W  = cnt_w(DEF_FEATURE_MAP_HEIGHT);
  localparam int CO_W = cnt_w(DEF_OUTPUT_NB_CHANNELS);
  localparam int CI_W = cnt_w(DEF_INPUT_NB_CHANNELS);
  localparam int K_W  = cnt_w(DEF_KERNEL_SIZE);

endpackage

// File: rtl/conv_loop_scheduler_wrap_counter.sv
// One loop index of the nest: counts 0..MAX and wraps, flagging its terminal value.
// Latency: value updates on the edge after inc; last is combinational from value.
// Backpressure: none; the caller only raises inc when the loop really advances.
module wrap_counter #(
  parameter int MAX = 1,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] value,
  output logic         last
);

  assign last = (value == W'(MAX));

  // Count with wrap; clr forces the index back to the start of its loop.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= last ? '0 : value + 1'b1;
    end
  end

endmodule

// File: rtl/conv_loop_scheduler.sv
// Sequences the conv loop nest (y, x, co, ky, kx, ci) and drives MAC/padding controls.
// Latency: one tap per cycle while streams are valid, plus one OUTPUT cycle per result.
// Backpressure: joint a/b handshake; nothing is consumed unless b (and a on unpadded taps) is valid.
module conv_loop_scheduler
  import conv_pkg::*;
#(
  parameter int FEATURE_MAP_WIDTH  = DEF_FEATURE_MAP_WIDTH,
  parameter int FEATURE_MAP_HEIGHT = DEF_FEATURE_MAP_HEIGHT,
  parameter int INPUT_NB_CHANNELS  = DEF_INPUT_NB_CHANNELS,
  parameter int OUTPUT_NB_CHANNELS = DEF_OUTPUT_NB_CHANNELS,
  parameter int KERNEL_SIZE        = DEF_KERNEL_SIZE
) (
  input  logic                                  clk,
  input  logic                                  arst_n_in,
  input  logic                                  start,
  output logic                                  running,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic                                  b_valid,
  output logic                                  b_ready,
  output logic                                  a_zero_flag,
  output logic                                  mac_en,
  output logic                                  mac_clear,
  output logic                                  output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

  localparam int XW = $clog2(FEATURE_MAP_WIDTH);
  localparam int YW = $clog2(FEATURE_MAP_HEIGHT);
  localparam int CW = $clog2(OUTPUT_NB_CHANNELS);
  localparam int IW = cnt_w(INPUT_NB_CHANNELS);
  localparam int KW = cnt_w(KERNEL_SIZE);
  localparam int KH = KERNEL_SIZE / 2;

  sched_state_t state, state_nxt;

  logic [IW-1:0] ci_val;
  logic [KW-1:0] kx_val, ky_val;
  logic [CW-1:0] co_val;
  logic [XW-1:0] x_val;
  logic [YW-1:0] y_val;
  logic          ci_last, kx_last, ky_last, co_last, x_last, y_last;

  logic in_idle, in_fetch, in_output;
  logic pad, first_tap, last_tap, last_out;
  logic ci_inc, kx_inc, ky_inc, co_inc, x_inc, y_inc;

  assign in_idle   = (state == IDLE);
  assign in_fetch  = (state == FETCH);
  assign in_output = (state == OUTPUT);

  assign first_tap = (ci_val == '0) && (kx_val == '0) && (ky_val == '0);
  assign last_tap  = ci_last && kx_last && ky_last;
  assign last_out  = co_last && x_last && y_last;

  // Inner loop advances on every b transfer; outer loop once per OUTPUT cycle.
  assign ci_inc = b_ready;
  assign kx_inc = ci_inc && ci_last;
  assign ky_inc = kx_inc && kx_last;
  assign co_inc = in_output;
  assign x_inc  = co_inc && co_last;
  assign y_inc  = x_inc && x_last;

  wrap_counter #(.MAX(INPUT_NB_CHANNELS - 1), .W(IW)) u_ci (
    .clk(clk), .arst_n(arst_n_in), .inc(ci_inc), .clr(in_idle), .value(ci_val), .last(ci_last));
  wrap_counter #(.MAX(KERNEL_SIZE - 1), .W(KW)) u_kx (
    .clk(clk), .arst_n(arst_n_in), .inc(kx_inc), .clr(in_idle), .value(kx_val), .last(kx_last));
  wrap_counter #(.MAX(KERNEL_SIZE - 1), .W(KW)) u_ky (
    .clk(clk), .arst_n(arst_n_in), .inc(ky_inc), .clr(in_idle), .value(ky_val), .last(ky_last));
  wrap_counter #(.MAX(OUTPUT_NB_CHANNELS - 1), .W(CW)) u_co (
    .clk(clk), .arst_n(arst_n_in), .inc(co_inc), .clr(in_idle), .value(co_val), .last(co_last));
  wrap_counter #(.MAX(FEATURE_MAP_WIDTH - 1), .W(XW)) u_x (
    .clk(clk), .arst_n(arst_n_in), .inc(x_inc), .clr(in_idle), .value(x_val), .last(x_last));
  wrap_counter #(.MAX(FEATURE_MAP_HEIGHT - 1), .W(YW)) u_y (
    .clk(clk), .arst_n(arst_n_in), .inc(y_inc), .clr(in_idle), .value(y_val), .last(y_last));

  // Tap position in the input map; anything outside is zero padding (same-padding).
  always_comb begin
    int ix;
    int iy;
    ix  = int'(x_val) + int'(kx_val) - KH;
    iy  = int'(y_val) + int'(ky_val) - KH;
    pad = (ix < 0) || (ix >= FEATURE_MAP_WIDTH) || (iy < 0) || (iy >= FEATURE_MAP_HEIGHT);
  end

  // State register.
  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and handshake/MAC controls; padded taps consume b only.
  always_comb begin
    state_nxt    = state;
    a_ready      = 1'b0;
    b_ready      = 1'b0;
    mac_en       = 1'b0;
    mac_clear    = 1'b0;
    output_valid = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = FETCH;
      end
      FETCH: begin
        a_ready   = a_valid && b_valid && !pad;
        b_ready   = b_valid && (a_valid || pad);
        mac_en    = b_ready;
        mac_clear = b_ready && first_tap;
        if (b_ready && last_tap) state_nxt = OUTPUT;
      end
      OUTPUT: begin
        output_valid = 1'b1;
        state_nxt    = last_out ? IDLE : FETCH;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign running     = !in_idle;
  assign a_zero_flag = in_fetch && pad;
  assign output_x    = x_val;
  assign output_y    = y_val;
  assign output_ch   = co_val;

endmodule

// File: tb/tb_conv_loop_scheduler.sv
// Randomized scoreboard bench for conv_loop_scheduler on a 4x4x2 -> 2 channel, 3x3 layer.
// Latency: expects one OUTPUT cycle after the last tap of every result.
// Backpressure: drives a_valid/b_valid all-on, b toggling, and random.
module tb_conv_loop_scheduler;

  localparam int W      = 4;
  localparam int H      = 4;
  localparam int ICH    = 2;
  localparam int OCH    = 2;
  localparam int K      = 3;
  localparam int TAPS   = ICH * K * K;
  localparam int NOUT   = W * H * OCH;
  localparam int BUDGET = 5000;

  logic       clk = 1'b0;
  logic       arst_n_in = 1'b0;
  logic       start = 1'b0;
  logic       a_valid = 1'b0;
  logic       b_valid = 1'b0;
  logic       running, a_ready, b_ready, a_zero_flag, mac_en, mac_clear, output_valid;
  logic [1:0] output_x, output_y;
  logic [0:0] output_ch;

  conv_loop_scheduler #(
    .FEATURE_MAP_WIDTH(W), .FEATURE_MAP_HEIGHT(H),
    .INPUT_NB_CHANNELS(ICH), .OUTPUT_NB_CHANNELS(OCH), .KERNEL_SIZE(K)
  ) dut (
    .clk(clk), .arst_n_in(arst_n_in), .start(start), .running(running),
    .a_valid(a_valid), .a_ready(a_ready), .b_valid(b_valid), .b_ready(b_ready),
    .a_zero_flag(a_zero_flag), .mac_en(mac_en), .mac_clear(mac_clear),
    .output_valid(output_valid), .output_x(output_x), .output_y(output_y),
    .output_ch(output_ch)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit pad;
    bit clr;
  } tap_t;

  typedef struct {
    int y;
    int x;
    int ch;
    int na;
    int npad;
    bit last;
  } out_t;

  tap_t tap_q[$];
  out_t out_q[$];

  int  n_tests = 0;
  int  n_fail = 0;
  int  out_count = 0;
  int  acc_nb = 0, acc_na = 0, acc_nz = 0, acc_nc = 0;
  bit  exp_running = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: enumerate the loop nest directly and classify each tap by geometry.
  task automatic build_layer();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        for (int co = 0; co < OCH; co++) begin
          out_t o;
          o.y = y; o.x = x; o.ch = co; o.na = 0; o.npad = 0;
          o.last = (y == H - 1) && (x == W - 1) && (co == OCH - 1);
          for (int ky = 0; ky < K; ky++)
            for (int kx = 0; kx < K; kx++)
              for (int ci = 0; ci < ICH; ci++) begin
                tap_t t;
                int ix, iy;
                ix = x + kx - K / 2;
                iy = y + ky - K / 2;
                t.pad = (ix < 0) || (ix >= W) || (iy < 0) || (iy >= H);
                t.clr = (ky == 0) && (kx == 0) && (ci == 0);
                tap_q.push_back(t);
                if (t.pad) o.npad++; else o.na++;
              end
          out_q.push_back(o);
        end
  endtask

  task automatic clear_acc();
    acc_nb = 0; acc_na = 0; acc_nz = 0; acc_nc = 0;
  endtask

  // Monitor: checks every visible cycle against the head of the scoreboard queues.
  always @(negedge clk) begin
    if (arst_n_in) begin
      check("running", running, exp_running);
      if (!running) begin
        check("idle_outputs_zero",
              {a_ready, b_ready, mac_en, mac_clear, a_zero_flag, output_valid}, 0);
      end else if (output_valid) begin
        check("output_cycle_no_handshake", {a_ready, b_ready, mac_en, mac_clear, a_zero_flag}, 0);
        if (out_q.size() == 0) begin
          check("unexpected_output_valid", 1, 0);
        end else begin
          out_t o;
          o = out_q.pop_front();
          check("out_y", output_y, o.y);
          check("out_x", output_x, o.x);
          check("out_ch", output_ch, o.ch);
          check("b_transfers_per_output", acc_nb, TAPS);
          check("a_transfers_per_output", acc_na, o.na);
          check("zero_flag_taps_per_output", acc_nz, o.npad);
          check("mac_clear_per_output", acc_nc, 1);
          out_count++;
          if (o.last) exp_running = 1'b0;
        end
        clear_acc();
      end else begin
        if (tap_q.size() == 0) begin
          check("tap_expected_in_fetch", 0, 1);
        end else begin
          tap_t t;
          bit exp_ar, exp_br;
          t = tap_q[0];
          exp_ar = a_valid && b_valid && !t.pad;
          exp_br = b_valid && (a_valid || t.pad);
          check("a_zero_flag", a_zero_flag, t.pad);
          check("a_ready", a_ready, exp_ar);
          check("b_ready", b_ready, exp_br);
          check("mac_en", mac_en, exp_br);
          check("mac_clear", mac_clear, exp_br && t.clr);
          if (b_ready) begin
            void'(tap_q.pop_front());
            acc_nb++;
            if (a_ready) acc_na++;
            if (a_zero_flag) acc_nz++;
            if (mac_clear) acc_nc++;
          end
        end
      end
    end
  end

  task automatic set_valids(input int mode, input int cyc);
    case (mode)
      0: begin a_valid = 1'b1; b_valid = 1'b1; end
      1: begin a_valid = 1'b1; b_valid = (cyc % 2 == 0); end
      default: begin
        a_valid = ($urandom_range(0, 3) != 0);
        b_valid = ($urandom_range(0, 3) != 0);
      end
    endcase
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_running"}, running, 0);
    check({tag, "_ctrl"}, {a_ready, b_ready, mac_en, mac_clear, a_zero_flag, output_valid}, 0);
    check({tag, "_coords"}, {output_y, output_x, output_ch}, 0);
  endtask

  // One layer: queue the expected results, pulse start, then drive until done or aborted.
  task automatic run_layer(input int mode, input bit mid_start, input int abort_after);
    int cyc;
    int lim;
    lim = (abort_after > 0) ? abort_after : NOUT;
    build_layer();
    out_count = 0;
    clear_acc();
    @(posedge clk);
    #1;
    start = 1'b1;
    set_valids(mode, 0);
    @(posedge clk);
    exp_running = 1'b1;
    cyc = 0;
    while (out_count < lim && cyc < BUDGET) begin
      #1;
      start = mid_start && (cyc == 150 || cyc == 151);
      set_valids(mode, cyc);
      @(posedge clk);
      cyc++;
    end
    check("layer_within_budget", (cyc < BUDGET) ? 1 : 0, 1);
    if (abort_after > 0) begin
      #2;
      arst_n_in = 1'b0;
      #1;
      check_all_zero("async_reset");
      tap_q.delete();
      out_q.delete();
      exp_running = 1'b0;
      clear_acc();
      repeat (2) @(posedge clk);
      #2;
      arst_n_in = 1'b1;
    end else begin
      check("outputs_per_layer", out_count, NOUT);
      #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      check("taps_left_after_layer", tap_q.size(), 0);
      check("outputs_left_after_layer", out_q.size(), 0);
    end
  endtask

  initial begin
    arst_n_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    arst_n_in = 1'b1;
    a_valid = 1'b1;
    b_valid = 1'b1;
    repeat (3) @(posedge clk);

    run_layer(0, 1'b0, 0);  // all streams valid
    run_layer(1, 1'b0, 0);  // b toggles every cycle
    run_layer(2, 1'b1, 0);  // random valids, start re-asserted mid-layer
    run_layer(0, 1'b0, 5);  // reset after the fifth result
    run_layer(2, 1'b0, 0);  // fresh layer after reset restarts at (0,0,0)

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
